inst_fetch_unit: RTL and testbench

//  Instruction fetch front end: the producer of the decoder's iInst/iCurPc stream.
//  - Generates sequential PCs and issues word reads to instruction memory over a valid/ready request channel.
//  - Buffers in-order responses with their PCs in a prefetch FIFO.
//  - Presents one instruction per cycle to the decoder.
//  - On a redirect (taken branch/jump flush) it discards in-flight and buffered work and restarts at the new PC.
//  - The decoder has no valid input, so empty slots are filled with NOP (addi x0,x0,0 = 32'h0000_0013).

---
 rtl/inst_fetch_unit.sv | 88 ++++++++
 tb/tb_inst_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential PC generator, in-order prefetch FIFO and NOP-filling
// instruction presenter with redirect flush.
module inst_fetch_unit #(
  parameter logic [31:0] pBootAddr  = 32'h0000_0000,
  parameter int          pFifoDepth = 4,
  parameter int          cXLEN      = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  output logic             oMemReqVld,
  output logic [cXLEN-1:0] oMemReqAddr,
  input  logic             iMemReqRdy,
  input  logic             iMemRspVld,
  input  logic [cXLEN-1:0] iMemRspData,
  input  logic             iRedirect,
  input  logic [cXLEN-1:0] iRedirectPc,
  input  logic             iReady,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oInstVld
);
  localparam int AW = $clog2(pFifoDepth);
  localparam int CW = AW + 1;
  localparam logic [cXLEN-1:0] NOP = cXLEN'(32'h0000_0013);
  logic [cXLEN-1:0] pc_mem_q [pFifoDepth];
  logic [cXLEN-1:0] dat_mem_q [pFifoDepth];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, out_q, disc_q, out_d;
  logic [cXLEN-1:0] fetch_pc_q, rsp_pc_q, inst_q, pc_q, redir_pc;
  logic vld_q, xfer, push, pop;
  // Occupancy counts in-flight requests too, so a pushed response always has a slot.
  assign oMemReqVld = !iRst && !iRedirect && (cnt_q + out_q < CW'(pFifoDepth));
  assign oMemReqAddr = fetch_pc_q;
  assign xfer = oMemReqVld && iMemReqRdy;
  assign push = iMemRspVld && disc_q == '0 && !iRedirect;
  assign pop = iReady && cnt_q != '0 && !iRedirect;
  assign out_d = out_q + CW'(xfer) - CW'(iMemRspVld);
  assign redir_pc = {iRedirectPc[cXLEN-1:2], 2'b00};
  assign oInst = inst_q;
  assign oCurPc = pc_q;
  assign oInstVld = vld_q;
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fetch_pc_q <= pBootAddr;
      rsp_pc_q <= pBootAddr;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      disc_q <= '0;
      inst_q <= NOP;
      pc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      if (iRedirect) begin
        fetch_pc_q <= redir_pc;
        rsp_pc_q <= redir_pc;
        wr_q <= '0;
        rd_q <= '0;
        cnt_q <= '0;
        disc_q <= out_d;
        inst_q <= NOP;
        vld_q <= 1'b0;
      end else begin
        if (xfer) fetch_pc_q <= fetch_pc_q + cXLEN'(4);
        if (iMemRspVld && disc_q != '0) disc_q <= disc_q - 1'b1;
        // Kept responses arrive in request order, so the tag is just a running PC.
        if (push) begin
          pc_mem_q[wr_q] <= rsp_pc_q;
          dat_mem_q[wr_q] <= iMemRspData;
          wr_q <= wr_q + 1'b1;
          rsp_pc_q <= rsp_pc_q + cXLEN'(4);
        end
        if (pop) begin
          inst_q <= dat_mem_q[rd_q];
          pc_q <= pc_mem_q[rd_q];
          vld_q <= 1'b1;
          rd_q <= rd_q + 1'b1;
        end else if (iReady) begin
          inst_q <= NOP;
          vld_q <= 1'b0;
        end
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and random fetch traffic against a queue-based reference
// with an in-order memory model of variable latency.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, rdy, rsp_vld, redir, ready;
  logic [31:0] rsp_data, redir_pc;
  logic req_vld, inst_vld;
  logic [31:0] req_addr, inst, cur_pc;
  inst_fetch_unit dut (
    .iClk(clk), .iRst(rst), .oMemReqVld(req_vld), .oMemReqAddr(req_addr),
    .iMemReqRdy(rdy), .iMemRspVld(rsp_vld), .iMemRspData(rsp_data),
    .iRedirect(redir), .iRedirectPc(redir_pc), .iReady(ready),
    .oInst(inst), .oCurPc(cur_pc), .oInstVld(inst_vld)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; int due; int ep;} req_t;
  req_t pend[$];
  logic [31:0] fifo[$];
  int cyc, ep, lat, tests, fails, vld_cnt;
  bit rand_rsp, found;
  logic [31:0] exp_fetch, e_inst, e_pc;
  logic e_vld;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic rv, e_req, xfer;
    req_t r;
    rv = !rst && pend.size() > 0 && pend[0].due <= cyc && !(rand_rsp && $urandom_range(3) == 0);
    rsp_vld = rv;
    rsp_data = rv ? f(pend[0].a) : $urandom;
    #1;
    e_req = !rst && !redir && (pend.size() + fifo.size() < 4);
    chk("req_vld", req_vld, e_req);
    if (e_req) chk("req_addr", req_addr, exp_fetch);
    xfer = e_req && rdy;
    if (rst) begin
      pend.delete();
      fifo.delete();
      exp_fetch = 32'h0;
      e_inst = NOP;
      e_pc = 32'h0;
      e_vld = 1'b0;
      ep++;
    end else begin
      if (redir) begin
        e_inst = NOP;
        e_vld = 1'b0;
      end else if (ready) begin
        if (fifo.size() > 0) begin
          e_pc = fifo.pop_front();
          e_inst = f(e_pc);
          e_vld = 1'b1;
        end else begin
          e_inst = NOP;
          e_vld = 1'b0;
        end
      end
      if (rv) begin
        r = pend.pop_front();
        if (!redir && r.ep == ep) fifo.push_back(r.a);
      end
      if (xfer) begin
        pend.push_back('{exp_fetch, cyc + lat, ep});
        exp_fetch += 32'd4;
      end
      if (redir) begin
        fifo.delete();
        exp_fetch = {redir_pc[31:2], 2'b00};
        ep++;
      end
    end
    @(posedge clk);
    #1;
    chk("inst_vld", inst_vld, e_vld);
    chk("inst", inst, e_inst);
    chk("cur_pc", cur_pc, e_pc);
    cyc++;
    if (e_vld) vld_cnt++;
    @(negedge clk);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    int v0;
    rst = 1'b1; rdy = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
    rsp_vld = 1'b0; rsp_data = 32'h0; lat = 1; rand_rsp = 1'b0;
    tests = 0; fails = 0; cyc = 0; ep = 0; vld_cnt = 0;
    exp_fetch = 32'h0; e_inst = NOP; e_pc = 32'h0; e_vld = 1'b0;
    @(negedge clk);
    ticks(2);
    rst = 1'b0;
    // Streaming with 1-cycle memory: after warm-up, one instruction every cycle.
    ticks(4);
    v0 = vld_cnt;
    ticks(20);
    chk("no_gaps", vld_cnt - v0, 20);
    // Decoder stall fills the prefetch budget and stops requests.
    ready = 1'b0;
    ticks(10);
    #1 chk("stall_req_off", req_vld, 1'b0);
    ready = 1'b1;
    ticks(8);
    // Memory back-pressure holds the request address.
    rdy = 1'b0;
    ticks(5);
    rdy = 1'b1;
    ticks(6);
    // Redirect with two requests outstanding on a 3-cycle memory.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2) found = 1'b1; else tick();
    end
    chk("t4_setup", found, 1'b1);
    redir = 1'b1; redir_pc = 32'h100;
    tick();
    redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (inst_vld) found = 1'b1;
    end
    chk("t4_first_vld", found, 1'b1);
    chk("t4_first_pc", cur_pc, 32'h100);
    ticks(6);
    // Redirect coinciding with a response and a pop.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && fifo.size() > 0) found = 1'b1; else tick();
    end
    chk("t5_setup", found, 1'b1);
    redir = 1'b1; redir_pc = 32'h102;
    tick();
    redir = 1'b0;
    #1 chk("t5_next_addr", req_addr, 32'h100);
    ticks(8);
    // Wrap of the fetch PC past the top of the address space.
    redir = 1'b1; redir_pc = 32'hFFFF_FFF9;
    tick();
    redir = 1'b0;
    ticks(8);
    // Reset mid-stream with three outstanding.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 3) found = 1'b1; else tick();
    end
    chk("t6_setup", found, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(10);
    // Random traffic.
    rand_rsp = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rdy = $urandom_range(3) != 0;
      ready = $urandom_range(4) != 0;
      lat = $urandom_range(4, 1);
      redir = $urandom_range(29) == 0;
      redir_pc = $urandom;
      rst = $urandom_range(299) == 0;
      tick();
    end
    rst = 1'b0; redir = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
